rv_mem_ctl: RTL and testbench

RV_MEM_CTL -- requirements
Module: rv_mem_ctl

---
 rtl/rv_mem_ctl_pkg.sv | 67 ++++++
 rtl/rv_mem_ctl_timeout_cnt.sv | 43 ++++
 rtl/rv_mem_ctl.sv | 121 ++++++++++++
 tb/tb_rv_mem_ctl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_ctl_pkg.sv
// ---------------------------------------------------------------------------
// rv_mem_ctl_pkg
// Shared parameters package for the multicycle RV core. Holds the ALU, IMM
// and WB select encodings used by the control unit and datapath, plus the
// memory-controller FSM states, access op enum and the NOP instruction word.
// ---------------------------------------------------------------------------
package rv_mem_ctl_pkg;

   // ALU operation select driven by rv_ctl into the datapath ALU.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   // Immediate format select for the immediate generator.
   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_t;

   // Register-file writeback source select.
   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MDR = 2'd1,
      WB_PC4 = 2'd2,
      WB_IMM = 2'd3
   } wb_sel_t;

   // Memory controller FSM states, kept as plain constants so older
   // blocks that compare raw state bits keep working.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Kind of memory access currently in flight.
   typedef enum logic [1:0] {
      OP_FETCH = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } mem_op_t;

   // addi x0, x0, 0 -- the instruction register powers up holding this.
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   // Strobe arbitration: fetch beats store beats load. The load strobe is
   // implied when neither of the others is set.
   function automatic mem_op_t sel_op(input logic irwrite, input logic memrw);
      if (irwrite)
         return OP_FETCH;
      else if (memrw)
         return OP_STORE;
      else
         return OP_LOAD;
   endfunction

endpackage

// File: rtl/rv_mem_ctl_timeout_cnt.sv
// ---------------------------------------------------------------------------
// rv_timeout_cnt
// 8-bit cycle counter used by rv_mem_ctl to bound how long it waits for a
// memory acknowledge.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : zero the count (access is starting)
//   enable     : count this cycle (FSM is in BUSY)
//   expired    : this is the TIMEOUT-th counted cycle
// ---------------------------------------------------------------------------
module rv_timeout_cnt #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT);

   logic [7:0] count;
   logic [7:0] count_next;

   assign count_next = count + 8'd1;

   // The count holds the number of BUSY cycles already completed, so the
   // cycle in which the incremented value hits LIMIT is the last one the
   // controller is allowed to wait.
   assign expired = enable && (count_next == LIMIT);

   // Clear has priority so a new access always starts from zero even if
   // the previous one left a stale count behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= 8'd0;
      else if (clear)
         count <= 8'd0;
      else if (enable)
         count <= count_next;
   end

endmodule

// File: rtl/rv_mem_ctl.sv
// ---------------------------------------------------------------------------
// rv_mem_ctl
// Memory access controller between the multicycle control unit (rv_ctl) and
// a request/acknowledge memory bus. Holds the instruction register and the
// memory data register, and stalls rv_ctl while an access is outstanding.
//   clk, rst_n          : clock, asynchronous active-low reset
//   irwrite/mdrwrite/memrw : fetch / load / store strobes from rv_ctl
//   addr, wdata         : access address and store data from the datapath
//   instr, mdr          : instruction register, memory data register
//   stall               : freezes rv_ctl while an access is pending
//   mem_req/we/addr/wdata : memory bus request (held stable while mem_req)
//   mem_rdata, mem_ack  : memory bus response, ack is a one-cycle pulse
//   mem_err             : sticky flag, set when an access times out
// ---------------------------------------------------------------------------
module rv_mem_ctl
   import rv_mem_ctl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        irwrite,
   input  logic        mdrwrite,
   input  logic        memrw,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] instr,
   output logic [31:0] mdr,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_err
);

   logic [1:0] state;
   mem_op_t    op;
   mem_op_t    next_op;
   logic       any_strobe;
   logic       start;
   logic       busy;
   logic       expired;

   assign any_strobe = irwrite || mdrwrite || memrw;
   assign start      = (state == ST_IDLE) && any_strobe;
   assign busy       = (state == ST_BUSY);
   assign next_op    = sel_op(irwrite, memrw);

   // Stall asserts in the same cycle the strobe appears so rv_ctl never
   // advances past an access that has not been issued yet. DONE drops
   // stall so rv_ctl can move on while we return to IDLE.
   assign stall = start || busy;

   rv_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (start),
      .enable  (busy),
      .expired (expired)
   );

   // Main FSM. The bus request fields are captured only on the IDLE->BUSY
   // edge, which keeps them stable for the whole time mem_req is high even
   // though the datapath address may change. Ack is checked before the
   // timeout so an ack on the final allowed cycle still delivers its data.
   // DONE is a one-cycle bubble that ignores both strobes (rv_ctl still
   // shows the old one) and any stray ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op        <= OP_FETCH;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         instr     <= NOP_INSTR;
         mdr       <= 32'd0;
         mem_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_strobe) begin
                  state     <= ST_BUSY;
                  op        <= next_op;
                  mem_addr  <= addr;
                  mem_wdata <= wdata;
                  mem_we    <= (next_op == OP_STORE);
                  mem_req   <= 1'b1;
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  if (op == OP_FETCH)
                     instr <= mem_rdata;
                  else if (op == OP_LOAD)
                     mdr <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= ST_DONE;
               end else if (expired) begin
                  mem_req <= 1'b0;
                  mem_err <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rv_mem_ctl.sv
// ---------------------------------------------------------------------------
// tb_rv_mem_ctl
// Self-checking bench for rv_mem_ctl built with TIMEOUT=4. A table of
// access records (strobes, address, data, ack cycle, expected results) is
// played through the controller, followed by hand-written sequences for
// reset values, a stray ack in IDLE and a reset in the middle of an access.
// ---------------------------------------------------------------------------
module tb_rv_mem_ctl;

   localparam int unsigned TB_TIMEOUT = 4;

   logic        clk;
   logic        rst_n;
   logic        irwrite;
   logic        mdrwrite;
   logic        memrw;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] instr;
   logic [31:0] mdr;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        mem_err;

   int errors;
   int checks;

   // One access: strobes and operands, the BUSY cycle on which the memory
   // acks (0 = never), and what the controller must show afterwards.
   typedef struct {
      logic        irw;
      logic        mdrw;
      logic        mrw;
      logic [31:0] vaddr;
      logic [31:0] vwdata;
      logic [31:0] vrdata;
      int          ackAt;
      logic        expWe;
      logic [31:0] expInstr;
      logic [31:0] expMdr;
      logic        expErr;
      int          expReq;
   } vec_t;

   vec_t vecs [8];
   vec_t postReset;

   rv_mem_ctl #(
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irwrite   (irwrite),
      .mdrwrite  (mdrwrite),
      .memrw     (memrw),
      .addr      (addr),
      .wdata     (wdata),
      .instr     (instr),
      .mdr       (mdr),
      .stall     (stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .mem_err   (mem_err)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges outside the bounded loops.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its required value.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Run one access from IDLE through DONE and back to IDLE. Called at a
   // falling edge with the controller idle.
   task automatic applyStimulus(input vec_t v);
      int reqCycles;
      irwrite  = v.irw;
      mdrwrite = v.mdrw;
      memrw    = v.mrw;
      addr     = v.vaddr;
      wdata    = v.vwdata;
      #1;
      checkOutput("stall_t0", 32'(stall), 32'd1);
      checkOutput("req_t0", 32'(mem_req), 32'd0);
      @(posedge clk);
      @(negedge clk);
      addr  = ~v.vaddr;
      wdata = ~v.vwdata;
      reqCycles = 0;
      while (mem_req === 1'b1 && reqCycles < 20) begin
         reqCycles++;
         checkOutput("busy_stall", 32'(stall), 32'd1);
         checkOutput("busy_addr", mem_addr, v.vaddr);
         checkOutput("busy_wdata", mem_wdata, v.vwdata);
         checkOutput("busy_we", 32'(mem_we), 32'(v.expWe));
         if (reqCycles == v.ackAt) begin
            mem_ack   = 1'b1;
            mem_rdata = v.vrdata;
         end
         @(posedge clk);
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
      end
      checkOutput("req_cycles", 32'(reqCycles), 32'(v.expReq));
      checkOutput("done_stall", 32'(stall), 32'd0);
      checkOutput("done_req", 32'(mem_req), 32'd0);
      checkOutput("done_instr", instr, v.expInstr);
      checkOutput("done_mdr", mdr, v.expMdr);
      checkOutput("done_err", 32'(mem_err), 32'(v.expErr));
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      @(posedge clk);
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      irwrite   = 1'b0;
      mdrwrite  = 1'b0;
      memrw     = 1'b0;
      #1;
      checkOutput("idle_req", 32'(mem_req), 32'd0);
      checkOutput("idle_stall", 32'(stall), 32'd0);
      checkOutput("idle_instr", instr, v.expInstr);
      checkOutput("idle_mdr", mdr, v.expMdr);
      @(negedge clk);
   endtask

   // Directed test sequence.
   initial begin
      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      irwrite   = 1'b0;
      mdrwrite  = 1'b0;
      memrw     = 1'b0;
      addr      = 32'h0;
      wdata     = 32'h0;
      mem_rdata = 32'h0;
      mem_ack   = 1'b0;

      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h0050_0093, 1, 1'b0, 32'h0050_0093, 32'h0,         1'b0, 1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3, 1'b0, 32'h0050_0093, 32'hDEAD_BEEF, 1'b0, 3};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'hAAAA_5555, 2, 1'b1, 32'h0050_0093, 32'hDEAD_BEEF, 1'b0, 2};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h5555_AAAA, 32'h00A0_0113, 1, 1'b0, 32'h00A0_0113, 32'hDEAD_BEEF, 1'b0, 1};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0208, 32'h0BAD_F00D, 32'h1111_1111, 1, 1'b1, 32'h00A0_0113, 32'hDEAD_BEEF, 1'b0, 1};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0,         32'h0000_0033, 4, 1'b0, 32'h0000_0033, 32'hDEAD_BEEF, 1'b0, 4};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0048, 32'h0,         32'h7777_7777, 0, 1'b0, 32'h0000_0033, 32'hDEAD_BEEF, 1'b1, 4};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 2, 1'b0, 32'h0000_0033, 32'hCAFE_F00D, 1'b1, 2};
      postReset = '{1'b1, 1'b0, 1'b0, 32'h0000_0080, 32'h0,       32'h0010_8093, 2, 1'b0, 32'h0010_8093, 32'h0,         1'b0, 2};

      repeat (2) @(negedge clk);
      checkOutput("rst_instr", instr, 32'h0000_0013);
      checkOutput("rst_mdr", mdr, 32'h0);
      checkOutput("rst_req", 32'(mem_req), 32'd0);
      checkOutput("rst_we", 32'(mem_we), 32'd0);
      checkOutput("rst_addr", mem_addr, 32'h0);
      checkOutput("rst_wdata", mem_wdata, 32'h0);
      checkOutput("rst_err", 32'(mem_err), 32'd0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] stray ack while idle");
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      checkOutput("spur_instr", instr, 32'h0000_0013);
      checkOutput("spur_mdr", mdr, 32'h0);
      checkOutput("spur_req", 32'(mem_req), 32'd0);
      checkOutput("spur_stall", 32'(stall), 32'd0);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         $display("[TB] vector %0d", i);
         applyStimulus(vecs[i]);
      end

      $display("[TB] reset during BUSY");
      irwrite = 1'b1;
      addr    = 32'h0000_0400;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid_req_before", 32'(mem_req), 32'd1);
      irwrite = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_req", 32'(mem_req), 32'd0);
      checkOutput("mid_instr", instr, 32'h0000_0013);
      checkOutput("mid_mdr", mdr, 32'h0);
      checkOutput("mid_err", 32'(mem_err), 32'd0);
      checkOutput("mid_stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("post_req", 32'(mem_req), 32'd0);
      checkOutput("post_stall", 32'(stall), 32'd0);
      applyStimulus(postReset);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
